// File: rtl/sm_dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: requester ids and the per-requester memory request bundle.
package sm_dmem_arb_pkg;

    localparam int DMEM_AW = 32;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } Req_Id;

    typedef struct packed {
        logic               we;
        logic [DMEM_AW-1:0] addr;
        logic [31:0]        wdata;
    } Mem_Req;

endpackage

// File: rtl/sm_dmem_arbiter_if.sv
// Bundle of both requester ports plus the data-memory side of the arbiter.
// slave = arbiter view, master = requesters/memory view.
interface sm_dmem_arbiter_if;

    logic        r0_req;
    logic        r0_we;
    logic [31:0] r0_addr;
    logic [31:0] r0_wdata;
    logic        r0_gnt;
    logic        r0_rvalid;

    logic        r1_req;
    logic        r1_we;
    logic [31:0] r1_addr;
    logic [31:0] r1_wdata;
    logic        r1_gnt;
    logic        r1_rvalid;

    logic [31:0] rdata;

    logic [31:0] dmAddr;
    logic        dmWe;
    logic [31:0] dmWData;
    logic [31:0] dmRData;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  dmRData,
        output r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rdata,
        output dmAddr, dmWe, dmWData
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output dmRData,
        input  r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, rdata,
        input  dmAddr, dmWe, dmWData
    );

endinterface

// File: rtl/sm_dmem_arbiter_pick.sv
// Combinational grant picker: a lone requester always wins; under contention the
// previous owner keeps the port until its run reaches MAX_BURST.
module sm_arb_pick
    import sm_dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 2,
    parameter int RUN_W     = 4
) (
    input  logic [1:0]       req_i,
    input  Req_Id            last_id_i,
    input  logic [RUN_W-1:0] run_i,
    output Req_Id            gnt_id_o,
    output logic             gnt_valid_o
);

    localparam logic [RUN_W-1:0] BURST_LIMIT = RUN_W'(MAX_BURST);

    always_comb begin
        gnt_id_o    = REQ_CPU;
        gnt_valid_o = 1'b0;
        case (req_i)
            2'b01: begin
                gnt_id_o    = REQ_CPU;
                gnt_valid_o = 1'b1;
            end
            2'b10: begin
                gnt_id_o    = REQ_DBG;
                gnt_valid_o = 1'b1;
            end
            2'b11: begin
                gnt_valid_o = 1'b1;
                if (run_i < BURST_LIMIT) begin
                    gnt_id_o = last_id_i;
                end else begin
                    gnt_id_o = (last_id_i == REQ_CPU) ? REQ_DBG : REQ_CPU;
                end
            end
            default: begin
                gnt_id_o    = REQ_CPU;
                gnt_valid_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sm_dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory with one-cycle read return.
// Optional `SM_DMEM_ARB_STAT_EN adds a saturating contention counter output.
module sm_dmem_arbiter
    import sm_dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 2,
    parameter int RUN_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sm_dmem_arbiter_if.slave   bus
`ifdef SM_DMEM_ARB_STAT_EN
    ,
    output logic [15:0]        stat_conflicts
`endif
);

    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    Req_Id            lastId_q, lastId_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             rdPend_q, rdPend_d;
    Req_Id            rdOwner_q, rdOwner_d;

    Req_Id            pickId;
    logic             pickValid;
    logic             gntValid;
    Mem_Req           r0Req, r1Req, selReq;

    sm_arb_pick #(
        .MAX_BURST (MAX_BURST),
        .RUN_W     (RUN_W)
    ) u_pick (
        .req_i       ({bus.r1_req, bus.r0_req}),
        .last_id_i   (lastId_q),
        .run_i       (run_q),
        .gnt_id_o    (pickId),
        .gnt_valid_o (pickValid)
    );

    // Grants are combinational, so they must be gated by reset to force all outputs low at once.
    assign gntValid = pickValid & rst_n;

    assign r0Req  = '{we: bus.r0_we, addr: bus.r0_addr, wdata: bus.r0_wdata};
    assign r1Req  = '{we: bus.r1_we, addr: bus.r1_addr, wdata: bus.r1_wdata};
    assign selReq = (pickId == REQ_DBG) ? r1Req : r0Req;

    assign bus.r0_gnt  = gntValid && (pickId == REQ_CPU);
    assign bus.r1_gnt  = gntValid && (pickId == REQ_DBG);
    assign bus.dmAddr  = gntValid ? selReq.addr  : '0;
    assign bus.dmWe    = gntValid ? selReq.we    : 1'b0;
    assign bus.dmWData = gntValid ? selReq.wdata : '0;

    assign bus.r0_rvalid = rdPend_q && (rdOwner_q == REQ_CPU);
    assign bus.r1_rvalid = rdPend_q && (rdOwner_q == REQ_DBG);
    assign bus.rdata     = rdPend_q ? bus.dmRData : '0;

    always_comb begin
        lastId_d  = lastId_q;
        run_d     = '0;
        rdPend_d  = 1'b0;
        rdOwner_d = rdOwner_q;
        if (gntValid) begin
            if (pickId == lastId_q) begin
                run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
            end else begin
                lastId_d = pickId;
                run_d    = RUN_W'(1);
            end
            if (!selReq.we) begin
                rdPend_d  = 1'b1;
                rdOwner_d = pickId;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastId_q  <= REQ_CPU;
            run_q     <= '0;
            rdPend_q  <= 1'b0;
            rdOwner_q <= REQ_CPU;
        end else begin
            lastId_q  <= lastId_d;
            run_q     <= run_d;
            rdPend_q  <= rdPend_d;
            rdOwner_q <= rdOwner_d;
        end
    end

`ifdef SM_DMEM_ARB_STAT_EN
    logic [15:0] statCount_q, statCount_d;

    always_comb begin
        statCount_d = statCount_q;
        if (bus.r0_req && bus.r1_req && (statCount_q != 16'hFFFF)) begin
            statCount_d = statCount_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statCount_q <= '0;
        end else begin
            statCount_q <= statCount_d;
        end
    end

    assign stat_conflicts = statCount_q;
`endif

endmodule

// File: tb/tb_sm_dmem_arbiter.sv
// Directed bench for sm_dmem_arbiter: a vector table for solo/write/contention traffic,
// then hand sequences for mid-read reset and strict alternation with MAX_BURST=1.
module tb_sm_dmem_arbiter;
    import sm_dmem_arb_pkg::*;

    typedef struct {
        logic        r0Req;
        logic        r0We;
        logic [31:0] r0Addr;
        logic [31:0] r0Wdata;
        logic        r1Req;
        logic        r1We;
        logic [31:0] r1Addr;
        logic [31:0] r1Wdata;
        logic        expGnt0;
        logic        expGnt1;
        logic        expRv0;
        logic        expRv1;
        logic [31:0] expRdata;
        logic [31:0] expAddr;
        logic        expWe;
        logic [31:0] expWData;
    } Vec;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checkCount = 0;
    int   passCount  = 0;
    Vec   vecs[$];

    sm_dmem_arbiter_if bus0();
    sm_dmem_arbiter_if bus1();

`ifdef SM_DMEM_ARB_STAT_EN
    logic [15:0] stat0;
    logic [15:0] stat1;
`endif

    sm_dmem_arbiter #(.MAX_BURST(2), .RUN_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
`ifdef SM_DMEM_ARB_STAT_EN
        ,
        .stat_conflicts (stat0)
`endif
    );

    sm_dmem_arbiter #(.MAX_BURST(1), .RUN_W(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
`ifdef SM_DMEM_ARB_STAT_EN
        ,
        .stat_conflicts (stat1)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read memory behind the main instance; dut1 only needs grant checks.
    logic [31:0] mem [0:255];
    logic [31:0] memRd = 32'h0;
    always @(posedge clk) begin
        if (bus0.dmWe) mem[bus0.dmAddr[7:0]] <= bus0.dmWData;
        memRd <= mem[bus0.dmAddr[7:0]];
    end
    assign bus0.dmRData = memRd;
    assign bus1.dmRData = 32'h0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                          input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                          input logic g0, input logic g1, input logic v0, input logic v1,
                          input logic [31:0] rd, input logic [31:0] ea, input logic ew,
                          input logic [31:0] ed);
        Vec v;
        v.r0Req = q0; v.r0We = w0; v.r0Addr = a0; v.r0Wdata = d0;
        v.r1Req = q1; v.r1We = w1; v.r1Addr = a1; v.r1Wdata = d1;
        v.expGnt0 = g0; v.expGnt1 = g1; v.expRv0 = v0; v.expRv1 = v1;
        v.expRdata = rd; v.expAddr = ea; v.expWe = ew; v.expWData = ed;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input Vec v);
        bus0.r0_req   = v.r0Req;
        bus0.r0_we    = v.r0We;
        bus0.r0_addr  = v.r0Addr;
        bus0.r0_wdata = v.r0Wdata;
        bus0.r1_req   = v.r1Req;
        bus0.r1_we    = v.r1We;
        bus0.r1_addr  = v.r1Addr;
        bus0.r1_wdata = v.r1Wdata;
    endtask

    task automatic checkVec(input Vec v, input int idx);
        checkOutput($sformatf("v%0d.r0_gnt", idx),    32'(bus0.r0_gnt),    32'(v.expGnt0));
        checkOutput($sformatf("v%0d.r1_gnt", idx),    32'(bus0.r1_gnt),    32'(v.expGnt1));
        checkOutput($sformatf("v%0d.r0_rvalid", idx), 32'(bus0.r0_rvalid), 32'(v.expRv0));
        checkOutput($sformatf("v%0d.r1_rvalid", idx), 32'(bus0.r1_rvalid), 32'(v.expRv1));
        checkOutput($sformatf("v%0d.rdata", idx),     bus0.rdata,          v.expRdata);
        checkOutput($sformatf("v%0d.dmAddr", idx),    bus0.dmAddr,         v.expAddr);
        checkOutput($sformatf("v%0d.dmWe", idx),      32'(bus0.dmWe),      32'(v.expWe));
        checkOutput($sformatf("v%0d.dmWData", idx),   bus0.dmWData,        v.expWData);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".r0_gnt"},    32'(bus0.r0_gnt),    32'h0);
        checkOutput({tag, ".r1_gnt"},    32'(bus0.r1_gnt),    32'h0);
        checkOutput({tag, ".r0_rvalid"}, 32'(bus0.r0_rvalid), 32'h0);
        checkOutput({tag, ".r1_rvalid"}, 32'(bus0.r1_rvalid), 32'h0);
        checkOutput({tag, ".rdata"},     bus0.rdata,          32'h0);
        checkOutput({tag, ".dmAddr"},    bus0.dmAddr,         32'h0);
        checkOutput({tag, ".dmWe"},      32'(bus0.dmWe),      32'h0);
        checkOutput({tag, ".dmWData"},   bus0.dmWData,        32'h0);
    endtask

    task automatic idleBus0();
        bus0.r0_req = 1'b0; bus0.r0_we = 1'b0; bus0.r0_addr = 32'h0; bus0.r0_wdata = 32'h0;
        bus0.r1_req = 1'b0; bus0.r1_we = 1'b0; bus0.r1_addr = 32'h0; bus0.r1_wdata = 32'h0;
    endtask

    task automatic idleBus1();
        bus1.r0_req = 1'b0; bus1.r0_we = 1'b0; bus1.r0_addr = 32'h0; bus1.r0_wdata = 32'h0;
        bus1.r1_req = 1'b0; bus1.r1_we = 1'b0; bus1.r1_addr = 32'h0; bus1.r1_wdata = 32'h0;
    endtask

    initial begin
        int gntSeq[5];
        idleBus0();
        idleBus1();

        // Solo write/read on r0, write-then-read on r1, then contention with reads on both.
        addVec(1,1,32'h10,32'hDEADBEEF, 0,0,32'h0,32'h0,        1,0,0,0, 32'h0,        32'h10,1, 32'hDEADBEEF);
        addVec(1,0,32'h10,32'h0,        0,0,32'h0,32'h0,        1,0,0,0, 32'h0,        32'h10,0, 32'h0);
        addVec(0,0,32'h0, 32'h0,        0,0,32'h0,32'h0,        0,0,1,0, 32'hDEADBEEF, 32'h0, 0, 32'h0);
        addVec(0,0,32'h0, 32'h0,        1,1,32'h20,32'h12345678,0,1,0,0, 32'h0,        32'h20,1, 32'h12345678);
        addVec(0,0,32'h0, 32'h0,        1,0,32'h20,32'h0,       0,1,0,0, 32'h0,        32'h20,0, 32'h0);
        addVec(0,0,32'h0, 32'h0,        0,0,32'h0,32'h0,        0,0,0,1, 32'h12345678, 32'h0, 0, 32'h0);
        addVec(1,0,32'h10,32'h0,        1,0,32'h20,32'h0,       0,1,0,0, 32'h0,        32'h20,0, 32'h0);
        addVec(1,0,32'h10,32'h0,        1,0,32'h20,32'h0,       0,1,0,1, 32'h12345678, 32'h20,0, 32'h0);
        addVec(1,0,32'h10,32'h0,        1,0,32'h20,32'h0,       1,0,0,1, 32'h12345678, 32'h10,0, 32'h0);
        addVec(1,0,32'h10,32'h0,        1,0,32'h20,32'h0,       1,0,1,0, 32'hDEADBEEF, 32'h10,0, 32'h0);
        addVec(1,0,32'h10,32'h0,        1,0,32'h20,32'h0,       0,1,1,0, 32'hDEADBEEF, 32'h20,0, 32'h0);
        addVec(0,0,32'h0, 32'h0,        0,0,32'h0,32'h0,        0,0,0,1, 32'h12345678, 32'h0, 0, 32'h0);
        addVec(0,0,32'h0, 32'h0,        0,0,32'h0,32'h0,        0,0,0,0, 32'h0,        32'h0, 0, 32'h0);

        // Outputs must stay low in reset even with requests pending.
        #1;
        bus0.r0_req = 1'b1; bus0.r0_addr = 32'h10;
        bus0.r1_req = 1'b1; bus0.r1_addr = 32'h20;
        #1;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("resetHeld");
        idleBus0();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkVec(vecs[i], i);
        end

`ifdef SM_DMEM_ARB_STAT_EN
        checkOutput("stat0.afterTable", 32'(stat0), 32'd5);
`endif

        // Reset asserted between a read grant and its return: the return must vanish.
        @(posedge clk);
        #1;
        bus0.r0_req = 1'b1; bus0.r0_we = 1'b0; bus0.r0_addr = 32'h10;
        @(negedge clk);
        checkOutput("midReset.grant", 32'(bus0.r0_gnt), 32'h1);
        @(posedge clk);
        #1;
        bus0.r1_req = 1'b1; bus0.r1_we = 1'b0; bus0.r1_addr = 32'h20;
        rst_n = 1'b0;
        #1;
        checkAllZero("midReset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // After release both request: r0 first, then bursts of two.
        gntSeq = '{0, 0, 1, 1, 0};
        checkOutput("postReset.r0_gnt.0", 32'(bus0.r0_gnt), 32'h1);
        checkOutput("postReset.r1_gnt.0", 32'(bus0.r1_gnt), 32'h0);
        checkOutput("postReset.rvalid.0", 32'({bus0.r1_rvalid, bus0.r0_rvalid}), 32'h0);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("postReset.r0_gnt.%0d", k), 32'(bus0.r0_gnt), 32'(gntSeq[k] == 0));
            checkOutput($sformatf("postReset.r1_gnt.%0d", k), 32'(bus0.r1_gnt), 32'(gntSeq[k] == 1));
            checkOutput($sformatf("postReset.r0_rvalid.%0d", k), 32'(bus0.r0_rvalid), 32'(gntSeq[k-1] == 0));
            checkOutput($sformatf("postReset.r1_rvalid.%0d", k), 32'(bus0.r1_rvalid), 32'(gntSeq[k-1] == 1));
            checkOutput($sformatf("postReset.rdata.%0d", k), bus0.rdata,
                        (gntSeq[k-1] == 1) ? 32'h12345678 : 32'hDEADBEEF);
        end
        @(posedge clk);
        #1;
        idleBus0();

        // MAX_BURST=1: strict alternation under contention.
        bus1.r0_req = 1'b1; bus1.r0_addr = 32'h40;
        bus1.r1_req = 1'b1; bus1.r1_addr = 32'h44;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checkOutput($sformatf("alt.r0_gnt.%0d", k), 32'(bus1.r0_gnt), 32'((k % 2) == 0));
            checkOutput($sformatf("alt.r1_gnt.%0d", k), 32'(bus1.r1_gnt), 32'((k % 2) == 1));
            @(posedge clk);
            #1;
        end

        // r0 alone keeps the port indefinitely.
        bus1.r1_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput($sformatf("solo.r0_gnt.%0d", k), 32'(bus1.r0_gnt), 32'h1);
            checkOutput($sformatf("solo.r1_gnt.%0d", k), 32'(bus1.r1_gnt), 32'h0);
`ifdef SM_DMEM_ARB_STAT_EN
            checkOutput($sformatf("stat1.%0d", k), 32'(stat1), 32'd7);
`endif
            @(posedge clk);
            #1;
        end
        idleBus1();

        @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
